// File: rtl/memory_stage.sv
// MEM stage: drives the memory controller and resolves branch taken (both combinational), and holds the MEM/WB register.
// Latency: strobes, address, store data and PCSrc have zero latency; MEM/WB outputs have 1 cycle.
// Backpressure: none; the controller answers within the cycle and the MEM/WB register captures every edge.
module memory_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result_from_execution,
    input  logic            flag_zero_from_execution,
    input  logic [XLEN-1:0] add_sum_from_execution,
    input  logic [XLEN-1:0] read_data_2_from_execution,
    input  logic [RD_W-1:0] immed_11_7_from_execution,
    input  logic            mem_read_control,
    input  logic            mem_write_control,
    input  logic            branch_control,
    input  logic [XLEN-1:0] read_data_from_memory_controller,
    output logic [XLEN-1:0] read_data_from_memory,
    output logic [XLEN-1:0] alu_result_from_memory,
    output logic [RD_W-1:0] immed_11_7_from_memory,
    output logic [XLEN-1:0] add_sum_from_memory,
    output logic            PCSrc_from_memory,
    output logic            read,
    output logic            write,
    output logic [XLEN-1:0] memory_addr,
    output logic [XLEN-1:0] data_to_write
);

    typedef struct packed {
        logic [XLEN-1:0] load_dat;
        logic [XLEN-1:0] alu_dat;
        logic [RD_W-1:0] rd_idx;
        logic [XLEN-1:0] target_dat;
    } memwb_t;

    memwb_t memwb_d;
    memwb_t memwb_q;

    // A store wins over a load when both strobes are requested.
    assign write             = mem_write_control;
    assign read              = mem_read_control & ~mem_write_control;
    assign memory_addr       = alu_result_from_execution;
    assign data_to_write     = read_data_2_from_execution;
    assign PCSrc_from_memory = branch_control & flag_zero_from_execution;

    always_comb begin
        memwb_d            = '0;
        memwb_d.load_dat   = read_data_from_memory_controller;
        memwb_d.alu_dat    = alu_result_from_execution;
        memwb_d.rd_idx     = immed_11_7_from_execution;
        memwb_d.target_dat = add_sum_from_execution;
    end

    // Load data is captured unconditionally; WB decides whether to use it.
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign read_data_from_memory  = memwb_q.load_dat;
    assign alu_result_from_memory = memwb_q.alu_dat;
    assign immed_11_7_from_memory = memwb_q.rd_idx;
    assign add_sum_from_memory    = memwb_q.target_dat;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, then randomized cycles checked against a reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_from_execution;
    logic        flag_zero_from_execution;
    logic [31:0] add_sum_from_execution;
    logic [31:0] read_data_2_from_execution;
    logic [4:0]  immed_11_7_from_execution;
    logic        mem_read_control;
    logic        mem_write_control;
    logic        branch_control;
    logic [31:0] read_data_from_memory_controller;
    logic [31:0] read_data_from_memory;
    logic [31:0] alu_result_from_memory;
    logic [4:0]  immed_11_7_from_memory;
    logic [31:0] add_sum_from_memory;
    logic        PCSrc_from_memory;
    logic        read;
    logic        write;
    logic [31:0] memory_addr;
    logic [31:0] data_to_write;

    always #5 clk = ~clk;

    memory_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk                              (clk),
        .rst                              (rst),
        .alu_result_from_execution        (alu_result_from_execution),
        .flag_zero_from_execution         (flag_zero_from_execution),
        .add_sum_from_execution           (add_sum_from_execution),
        .read_data_2_from_execution       (read_data_2_from_execution),
        .immed_11_7_from_execution        (immed_11_7_from_execution),
        .mem_read_control                 (mem_read_control),
        .mem_write_control                (mem_write_control),
        .branch_control                   (branch_control),
        .read_data_from_memory_controller (read_data_from_memory_controller),
        .read_data_from_memory            (read_data_from_memory),
        .alu_result_from_memory           (alu_result_from_memory),
        .immed_11_7_from_memory           (immed_11_7_from_memory),
        .add_sum_from_memory              (add_sum_from_memory),
        .PCSrc_from_memory                (PCSrc_from_memory),
        .read                             (read),
        .write                            (write),
        .memory_addr                      (memory_addr),
        .data_to_write                    (data_to_write)
    );

    typedef struct {
        logic        rst;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] add;
        logic [31:0] rd2;
        logic [4:0]  imm;
        logic        mr;
        logic        mw;
        logic        br;
        logic [31:0] ctl_early;
        logic [31:0] ctl_late;
        logic        e_read;
        logic        e_write;
        logic        e_pc;
        logic [31:0] e_rdata;
        logic [31:0] e_alu;
        logic [4:0]  e_imm;
        logic [31:0] e_add;
    } vec_t;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    bit          have_prev = 1'b0;
    logic [31:0] prev_rdata, prev_alu, prev_add;
    logic [4:0]  prev_imm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] alu, input logic zero,
                                input logic [31:0] add, input logic [31:0] rd2, input logic [4:0] imm,
                                input logic mr, input logic mw, input logic br,
                                input logic [31:0] ce, input logic [31:0] cl,
                                input logic er, input logic ew, input logic ep,
                                input logic [31:0] erd, input logic [31:0] ealu,
                                input logic [4:0] eimm, input logic [31:0] eadd);
        vec_t v;
        v.rst = r; v.alu = alu; v.zero = zero; v.add = add; v.rd2 = rd2; v.imm = imm;
        v.mr = mr; v.mw = mw; v.br = br; v.ctl_early = ce; v.ctl_late = cl;
        v.e_read = er; v.e_write = ew; v.e_pc = ep;
        v.e_rdata = erd; v.e_alu = ealu; v.e_imm = eimm; v.e_add = eadd;
        return v;
    endfunction

    // Reference: strobes follow the ISA intent (store beats load); MEM/WB copies what was present at the edge.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        m.e_write = v.mw;
        m.e_read  = v.mw ? 1'b0 : v.mr;
        m.e_pc    = (v.br && v.zero) ? 1'b1 : 1'b0;
        if (v.rst) begin
            m.e_rdata = 32'd0; m.e_alu = 32'd0; m.e_imm = 5'd0; m.e_add = 32'd0;
        end else begin
            m.e_rdata = v.ctl_late; m.e_alu = v.alu; m.e_imm = v.imm; m.e_add = v.add;
        end
        return m;
    endfunction

    task automatic run_cycle(input vec_t v);
        @(negedge clk);
        rst                              = v.rst;
        alu_result_from_execution        = v.alu;
        flag_zero_from_execution         = v.zero;
        add_sum_from_execution           = v.add;
        read_data_2_from_execution       = v.rd2;
        immed_11_7_from_execution        = v.imm;
        mem_read_control                 = v.mr;
        mem_write_control                = v.mw;
        branch_control                   = v.br;
        read_data_from_memory_controller = v.ctl_early;
        #1;
        chk("read", {31'd0, read}, {31'd0, v.e_read});
        chk("write", {31'd0, write}, {31'd0, v.e_write});
        chk("pcsrc", {31'd0, PCSrc_from_memory}, {31'd0, v.e_pc});
        chk("memory_addr", memory_addr, v.alu);
        chk("data_to_write", data_to_write, v.rd2);
        if (have_prev) begin
            chk("hold_rdata", read_data_from_memory, prev_rdata);
            chk("hold_alu", alu_result_from_memory, prev_alu);
            chk("hold_imm", {27'd0, immed_11_7_from_memory}, {27'd0, prev_imm});
            chk("hold_add", add_sum_from_memory, prev_add);
        end
        #2;
        read_data_from_memory_controller = v.ctl_late;
        @(posedge clk);
        #1;
        chk("reg_rdata", read_data_from_memory, v.e_rdata);
        chk("reg_alu", alu_result_from_memory, v.e_alu);
        chk("reg_imm", {27'd0, immed_11_7_from_memory}, {27'd0, v.e_imm});
        chk("reg_add", add_sum_from_memory, v.e_add);
        prev_rdata = v.e_rdata; prev_alu = v.e_alu; prev_imm = v.e_imm; prev_add = v.e_add;
        have_prev  = 1'b1;
        n_vec++;
    endtask

    localparam logic [31:0] F = 32'hFFFF_FFFF;
    localparam logic [31:0] Z = 32'h0;

    vec_t tbl[14];

    initial begin
        rst = 1'b1;
        alu_result_from_execution = Z; flag_zero_from_execution = 1'b0;
        add_sum_from_execution = Z; read_data_2_from_execution = Z;
        immed_11_7_from_execution = 5'd0; mem_read_control = 1'b0;
        mem_write_control = 1'b0; branch_control = 1'b0;
        read_data_from_memory_controller = Z;

        //            rst alu           z  add           rd2           imm    mr mw br ctl_early     ctl_late      rd wr pc e_rdata       e_alu         e_imm  e_add
        tbl[0]  = mk(1, F,            1, F,            F,            5'h1F, 1, 1, 1, F,            F,            0, 1, 1, Z,            Z,            5'h00, Z);
        tbl[1]  = mk(1, F,            1, F,            F,            5'h1F, 1, 1, 1, F,            F,            0, 1, 1, Z,            Z,            5'h00, Z);
        tbl[2]  = mk(0, Z,            0, Z,            Z,            5'h00, 1, 0, 0, Z,            F,            1, 0, 0, F,            Z,            5'h00, Z);
        tbl[3]  = mk(0, F,            0, F,            Z,            5'h1F, 0, 0, 0, Z,            Z,            0, 0, 0, Z,            F,            5'h1F, F);
        tbl[4]  = mk(0, 32'h100,      0, Z,            32'hDEADBEEF, 5'h03, 0, 1, 0, 32'h12345678, 32'h12345678, 0, 1, 0, 32'h12345678, 32'h100,      5'h03, Z);
        tbl[5]  = mk(0, 32'h100,      0, Z,            32'hDEADBEEF, 5'h03, 1, 1, 0, 32'h12345678, 32'h12345678, 0, 1, 0, 32'h12345678, 32'h100,      5'h03, Z);
        tbl[6]  = mk(0, Z,            1, 32'h40,       Z,            5'h00, 0, 0, 1, Z,            Z,            0, 0, 1, Z,            Z,            5'h00, 32'h40);
        tbl[7]  = mk(0, Z,            0, 32'h44,       Z,            5'h00, 0, 0, 1, Z,            Z,            0, 0, 0, Z,            Z,            5'h00, 32'h44);
        tbl[8]  = mk(0, Z,            1, 32'h48,       Z,            5'h00, 0, 0, 0, Z,            Z,            0, 0, 0, Z,            Z,            5'h00, 32'h48);
        tbl[9]  = mk(0, 32'h11111111, 0, 32'h22222222, Z,            5'h05, 0, 0, 0, 32'hAAAA0001, 32'hAAAA0001, 0, 0, 0, 32'hAAAA0001, 32'h11111111, 5'h05, 32'h22222222);
        tbl[10] = mk(0, 32'h33333333, 0, 32'h44444444, Z,            5'h06, 0, 0, 0, 32'hAAAA0002, 32'hAAAA0002, 0, 0, 0, 32'hAAAA0002, 32'h33333333, 5'h06, 32'h44444444);
        tbl[11] = mk(0, 32'h55555555, 0, 32'h66666666, Z,            5'h07, 0, 0, 0, 32'hAAAA0003, 32'hAAAA0003, 0, 0, 0, 32'hAAAA0003, 32'h55555555, 5'h07, 32'h66666666);
        tbl[12] = mk(1, 32'h77777777, 1, 32'h88888888, 32'h0BADF00D, 5'h08, 1, 0, 1, 32'hAAAA0004, 32'hAAAA0004, 1, 0, 1, Z,            Z,            5'h00, Z);
        tbl[13] = mk(0, 32'h99999999, 0, 32'hAAAAAAAA, Z,            5'h09, 0, 0, 0, 32'hAAAA0005, 32'hAAAA0005, 0, 0, 0, 32'hAAAA0005, 32'h99999999, 5'h09, 32'hAAAAAAAA);

        for (int i = 0; i < 14; i++) run_cycle(tbl[i]);

        // Hand sequence: reset held several edges keeps outputs at zero, then capture resumes.
        for (int i = 0; i < 3; i++)
            run_cycle(mk(1, 32'hCAFE0000 + i, 1, 32'hBEEF0000 + i, F, 5'h15, 1, 0, 1, F, 32'h5A5A5A5A,
                         1, 0, 1, Z, Z, 5'h00, Z));
        run_cycle(mk(0, 32'h0000ABCD, 0, 32'h00001234, Z, 5'h0A, 1, 0, 0, 32'h01010101, 32'h80000001,
                     1, 0, 0, 32'h80000001, 32'h0000ABCD, 5'h0A, 32'h00001234));

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v.rst       = ($urandom_range(0, 15) == 0);
            v.alu       = $urandom;
            v.zero      = $urandom_range(0, 1);
            v.add       = $urandom;
            v.rd2       = $urandom;
            v.imm       = 5'($urandom_range(0, 31));
            v.mr        = $urandom_range(0, 1);
            v.mw        = $urandom_range(0, 1);
            v.br        = $urandom_range(0, 1);
            v.ctl_early = $urandom;
            v.ctl_late  = ($urandom_range(0, 1) == 1) ? v.ctl_early : 32'($urandom);
            run_cycle(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, between the EX/MEM boundary and writeback.
- Forwards load/store requests to the external memory controller combinationally.
- Resolves branch taken (PCSrc) for the fetch stage.
- Holds the MEM/WB pipeline register (load data, ALU result, rd index, branch target) for the writeback stage.

Parameters:
- XLEN, 32, datapath width for addresses and data.
- RD_W, 5, width of the destination register index (instruction bits 11:7).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- alu_result_from_execution  in  XLEN  ALU result from EX; memory address for loads/stores.
- flag_zero_from_execution  in  1  ALU zero flag from EX.
- add_sum_from_execution  in  XLEN  branch target (PC + offset) from EX.
- read_data_2_from_execution  in  XLEN  rs2 value; store data.
- immed_11_7_from_execution  in  RD_W  destination register index.
- mem_read_control  in  1  load enable.
- mem_write_control  in  1  store enable.
- branch_control  in  1  instruction is a conditional branch.
- read_data_from_memory_controller  in  XLEN  load data returned by the memory controller, valid within the cycle.
- read_data_from_memory  out  XLEN  registered load data to WB.
- alu_result_from_memory  out  XLEN  registered ALU result to WB.
- immed_11_7_from_memory  out  RD_W  registered rd index to WB.
- add_sum_from_memory  out  XLEN  registered branch target.
- PCSrc_from_memory  out  1  branch taken, combinational.
- read  out  1  read strobe to memory controller.
- write  out  1  write strobe to memory controller.
- memory_addr  out  XLEN  address to memory controller.
- data_to_write  out  XLEN  store data to memory controller.

Behaviour:
- Combinational outputs (no latency, independent of clk/rst):
  - memory_addr = alu_result_from_execution.
  - data_to_write = read_data_2_from_execution.
  - write = mem_write_control.
  - read = mem_read_control AND NOT mem_write_control. If both are asserted, the write has priority and read is suppressed.
  - PCSrc_from_memory = branch_control AND flag_zero_from_execution.
- Pipeline register, updated on every rising edge of clk:
  - read_data_from_memory <= read_data_from_memory_controller, sampled at the edge. The value may change mid-cycle; only the value present at the edge counts. It is captured unconditionally, whatever the value of mem_read_control.
  - alu_result_from_memory <= alu_result_from_execution.
  - immed_11_7_from_memory <= immed_11_7_from_execution.
  - add_sum_from_memory <= add_sum_from_execution.
  - Latency is 1 cycle from input to registered output. There is no stall or enable; a new value is captured every cycle.
- Reset:
  - When rst=1 at a rising edge, all four registered outputs become 0 and stay 0 while rst is held.
  - Reset overrides capture.
  - Combinational outputs are not affected by rst; they track their inputs during reset.
  - Registered outputs before the first edge are don't-care; the bench must apply reset first.
- Widths: all paths are bit-exact copies. No sign or zero extension and no arithmetic in this stage.
- There is no handshake with the memory controller. The controller returns read data within the same cycle.

Test Plan:
- Reset: rst=1 for 2 edges with all inputs 0xFFFFFFFF / 5'h1F -> all four registered outputs 0; memory_addr=0xFFFFFFFF and data_to_write=0xFFFFFFFF during reset.
- Load capture: rst=0, mem_read_control=1, alu_result=0x00000000; controller data changes 0x00000000 -> 0xFFFFFFFF mid-cycle -> read=1 and memory_addr=0 during the cycle; after the edge read_data_from_memory=0xFFFFFFFF.
- Pass-through: alu_result=0xFFFFFFFF, add_sum=0xFFFFFFFF, immed=5'h1F, mem_read=0, mem_write=0, branch=0 -> read=0, write=0, PCSrc=0; after 1 edge alu_result_from_memory=0xFFFFFFFF, add_sum_from_memory=0xFFFFFFFF, immed_11_7_from_memory=5'h1F.
- Store: mem_write=1, read_data_2=0xDEADBEEF, alu_result=0x00000100 -> write=1, read=0, data_to_write=0xDEADBEEF, memory_addr=0x100 in the same cycle. Repeat with mem_read=1 also asserted -> read stays 0.
- Branch resolve: branch=1 with zero=1 -> PCSrc=1. branch=1, zero=0 -> 0. branch=0, zero=1 -> 0. add_sum=0x00000040 appears on add_sum_from_memory after 1 edge.
- Mid-operation reset: stream distinct values for 3 cycles, assert rst for 1 edge -> registered outputs become 0 at that edge. Deassert rst -> capture resumes on the next edge with the current inputs.
